// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: accepts a word over valid/ready and
// shifts it out one bit per enabled cycle, then pulses done.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for a word, load_ready high once out of reset
  // SHIFT | presenting shreg output bit, advancing on shift_en
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t         state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           shreg_en, cnt_en;
  // Holds load_ready low until the first edge after reset release.
  logic           armed_q, armed_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      if (shreg_en) shreg_q <= shreg_d;
      if (cnt_en)   cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    shreg_en = 1'b0;
    cnt_d    = cnt_q;
    cnt_en   = 1'b0;
    armed_d  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (load_valid && armed_q) begin
          shreg_d  = load_data;
          shreg_en = 1'b1;
          cnt_d    = '0;
          cnt_en   = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end else begin
            if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            else           shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            shreg_en = 1'b1;
            cnt_d    = cnt_q + CW'(1);
            cnt_en   = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state_q == ST_IDLE) && armed_q;
    ser_valid  = (state_q == ST_SHIFT);
    busy       = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    done       = (state_q == ST_DONE);
    ser_out    = 1'b0;
    if (state_q == ST_SHIFT) ser_out = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: MSB-first and LSB-first instances share stimulus.
module tb_piso_shift_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       shift_en = 1'b1;

  logic ready_m, so_m, sv_m, busy_m, done_m;
  logic ready_l, so_l, sv_l, busy_l, done_l;

  int n_checks = 0;
  int n_fail = 0;

  // per-cycle records, index c = cycle N+c after the handshake edge N
  logic r_so_m[0:39], r_sv_m[0:39], r_busy_m[0:39], r_done_m[0:39], r_rdy_m[0:39];
  logic r_so_l[0:39], r_sv_l[0:39], r_done_l[0:39];
  logic en_sched[0:39];

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(ready_m),
    .load_data(load_data), .shift_en(shift_en), .ser_out(so_m),
    .ser_valid(sv_m), .busy(busy_m), .done(done_m));

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(ready_l),
    .load_data(load_data), .shift_en(shift_en), .ser_out(so_l),
    .ser_valid(sv_l), .busy(busy_l), .done(done_l));

  task automatic clear_sched();
    for (int i = 0; i < 40; i++) en_sched[i] = 1'b1;
  endtask

  // mode 0: single word; 1: inject 0xFF while busy; 2: back-to-back with second word w2
  task automatic run_word(input logic [7:0] w, input int mode, input logic [7:0] w2, input int n);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = w;
    shift_en   = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      r_so_m[c] = so_m;  r_sv_m[c] = sv_m;  r_busy_m[c] = busy_m;
      r_done_m[c] = done_m;  r_rdy_m[c] = ready_m;
      r_so_l[c] = so_l;  r_sv_l[c] = sv_l;  r_done_l[c] = done_l;
      shift_en = en_sched[c];
      case (mode)
        1: begin
          load_valid = (c < 10);
          load_data  = 8'hFF;
        end
        2: begin
          load_valid = (c < 11);
          load_data  = w2;
        end
        default: load_valid = 1'b0;
      endcase
    end
    load_valid = 1'b0;
    shift_en   = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_checks++;
    if ({ready_m, so_m, sv_m, busy_m, done_m} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000", {ready_m, so_m, sv_m, busy_m, done_m});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready_m !== 1'b1 || ready_l !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b/%b expected 1/1", ready_m, ready_l);
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] exp;
    exp = 8'b10110100;
    clear_sched();
    run_word(8'hB4, 0, 8'h00, 11);
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if (r_so_m[c] !== exp[8-c] || r_sv_m[c] !== 1'b1 || r_done_m[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL msb_bit%0d: got so=%b sv=%b done=%b expected so=%b sv=1 done=0",
                 c, r_so_m[c], r_sv_m[c], r_done_m[c], exp[8-c]);
      end
    end
    n_checks++;
    if (r_done_m[9] !== 1'b1 || r_sv_m[9] !== 1'b0 || r_busy_m[9] !== 1'b1 || r_rdy_m[9] !== 1'b0) begin
      n_fail++;
      $display("FAIL msb_done_cycle: got done=%b sv=%b busy=%b rdy=%b expected 1 0 1 0",
               r_done_m[9], r_sv_m[9], r_busy_m[9], r_rdy_m[9]);
    end
    n_checks++;
    if (r_done_m[10] !== 1'b0 || r_rdy_m[10] !== 1'b1 || r_busy_m[10] !== 1'b0) begin
      n_fail++;
      $display("FAIL msb_after_done: got done=%b rdy=%b busy=%b expected 0 1 0",
               r_done_m[10], r_rdy_m[10], r_busy_m[10]);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp;
    int nvalid;
    exp = 8'b00101101;
    nvalid = 0;
    clear_sched();
    run_word(8'hB4, 0, 8'h00, 11);
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if (r_so_l[c] !== exp[8-c]) begin
        n_fail++;
        $display("FAIL lsb_bit%0d: got %b expected %b", c, r_so_l[c], exp[8-c]);
      end
    end
    for (int c = 1; c <= 11; c++) if (r_sv_l[c] === 1'b1) nvalid++;
    n_checks++;
    if (nvalid !== 8 || r_done_l[9] !== 1'b1) begin
      n_fail++;
      $display("FAIL lsb_valid_count: got %0d done9=%b expected 8 done9=1", nvalid, r_done_l[9]);
    end
  endtask

  task automatic test_stall();
    logic exp_so[1:11];
    logic [10:0] pat;
    pat = 11'b10111_110100;
    for (int c = 1; c <= 11; c++) exp_so[c] = pat[11-c];
    clear_sched();
    en_sched[3] = 1'b0; en_sched[4] = 1'b0; en_sched[5] = 1'b0;
    run_word(8'hB4, 0, 8'h00, 14);
    for (int c = 1; c <= 11; c++) begin
      n_checks++;
      if (r_so_m[c] !== exp_so[c] || r_sv_m[c] !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: got so=%b sv=%b expected so=%b sv=1",
                 c, r_so_m[c], r_sv_m[c], exp_so[c]);
      end
    end
    n_checks++;
    if (r_done_m[11] !== 1'b0 || r_done_m[12] !== 1'b1 || r_done_m[13] !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_done: got done11..13=%b%b%b expected 010",
               r_done_m[11], r_done_m[12], r_done_m[13]);
    end
  endtask

  task automatic test_load_while_busy();
    logic [7:0] exp;
    exp = 8'b10110100;
    clear_sched();
    run_word(8'hB4, 1, 8'h00, 12);
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if (r_so_m[c] !== exp[8-c] || r_rdy_m[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_load_bit%0d: got so=%b rdy=%b expected so=%b rdy=0",
                 c, r_so_m[c], r_rdy_m[c], exp[8-c]);
      end
    end
    n_checks++;
    if (r_rdy_m[9] !== 1'b0 || r_done_m[9] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_load_done: got rdy=%b done=%b expected 0 1", r_rdy_m[9], r_done_m[9]);
    end
    n_checks++;
    if (r_busy_m[11] !== 1'b0 || r_busy_m[12] !== 1'b0 || r_rdy_m[11] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_load_not_taken: got busy11=%b busy12=%b rdy11=%b expected 0 0 1",
               r_busy_m[11], r_busy_m[12], r_rdy_m[11]);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp;
    logic saw_done;
    exp = 8'b00001111;
    saw_done = 1'b0;
    clear_sched();
    run_word(8'hB4, 0, 8'h00, 4);
    n_checks++;
    if (r_so_m[4] !== 1'b1 || sv_m !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: got so4=%b sv=%b expected 1 1", r_so_m[4], sv_m);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy_m, sv_m, so_m, done_m, ready_m} !== 5'b0) begin
      n_fail++;
      $display("FAIL areset_immediate: got busy/sv/so/done/rdy=%b expected 00000",
               {busy_m, sv_m, so_m, done_m, ready_m});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done_m === 1'b1 || done_l === 1'b1) saw_done = 1'b1;
    end
    reset = 1'b0;
    @(negedge clk);
    if (done_m === 1'b1) saw_done = 1'b1;
    n_checks++;
    if (saw_done !== 1'b0 || ready_m !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_no_done: got saw_done=%b rdy=%b expected 0 1", saw_done, ready_m);
    end
    clear_sched();
    run_word(8'h0F, 0, 8'h00, 10);
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if (r_so_m[c] !== exp[8-c]) begin
        n_fail++;
        $display("FAIL areset_0f_bit%0d: got %b expected %b", c, r_so_m[c], exp[8-c]);
      end
    end
    n_checks++;
    if (r_done_m[9] !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_0f_done: got %b expected 1", r_done_m[9]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    logic exp_bit;
    int done_pos[$];
    exp = 16'b10100101_00111100;
    clear_sched();
    run_word(8'hA5, 2, 8'h3C, 22);
    for (int c = 1; c <= 20; c++) begin
      if (r_done_m[c] === 1'b1) done_pos.push_back(c);
      if (c == 9 || c == 10 || c == 19 || c == 20) continue;
      exp_bit = (c < 9) ? exp[16-c] : exp[18-c];
      n_checks++;
      if (r_so_m[c] !== exp_bit || r_sv_m[c] !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got so=%b sv=%b expected so=%b sv=1",
                 c, r_so_m[c], r_sv_m[c], exp_bit);
      end
    end
    n_checks++;
    if (done_pos.size() != 2 || done_pos[0] != 9 || done_pos[1] != 19) begin
      n_fail++;
      $display("FAIL b2b_done_pulses: got count=%0d first=%0d second=%0d expected 2 9 19",
               done_pos.size(), (done_pos.size() > 0) ? done_pos[0] : -1,
               (done_pos.size() > 1) ? done_pos[1] : -1);
    end
    n_checks++;
    if (r_rdy_m[10] !== 1'b1 || r_busy_m[21] !== 1'b0 || r_busy_m[22] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_third_word: got rdy10=%b busy21=%b busy22=%b expected 1 0 0",
               r_rdy_m[10], r_busy_m[21], r_busy_m[22]);
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_stall();
    test_load_while_busy();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
